ejector_i: RTL and testbench
============================

Name: ejector_i

Overview:
- Ejection stage of a minimally buffered deflection-router (MinBD) node, placed between the input pipeline register and the deflection permutation network.
- Each cycle it scans the four incoming flits (N, S, E, W). It picks at most one valid flit addressed to this node and delivers it to the local port.
- The chosen flit's slot is cleared. All other flits pass through unchanged to the routing stage.
- Outputs are registered, giving one cycle of latency.

Parameters:
- FLIT_W, 11, flit width. Bit [FLIT_W-1] is the valid bit; bits [5:0] are the destination address.
- LOCAL_ADDR, 6'b100100, this node's address, compared against flit bits [5:0].

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  reset, synchronous, active-high.
- northad  input  11  flit arriving from north.
- southad  input  11  flit arriving from south.
- eastad  input  11  flit arriving from east.
- westad  input  11  flit arriving from west.
- nad  output  11  north slot toward the router.
- sad  output  11  south slot toward the router.
- ead  output  11  east slot toward the router.
- wad  output  11  west slot toward the router.
- lad  output  11  ejected flit to the local core; lad[10] = ejection valid.

Behaviour:
- Reset: on a rising clk edge with rst=1, nad, sad, ead, wad, lad all become 11'b0. The round-robin pointer (if built) goes to N. rst has priority over every other update.
- Match rule: a flit is eligible when bit[10]=1 and bits[5:0]==LOCAL_ADDR.
  - Bit[10]=0 marks an empty slot; it is never ejected and is passed through bit-exact.
  - X/Z on an input is treated as not eligible. Do not add X-propagation logic.
- Selection: at most one flit is ejected per cycle.
  - Default fixed priority: N > S > E > W.
  - Other eligible flits are not ejected. They pass through and get deflected onward (no buffering here).
- Outputs, registered at the next rising edge:
  - The ejected slot's output becomes 11'b0.
  - Non-ejected slots copy their input unchanged.
  - lad = the ejected flit (bit[10]=1), or 11'b0 if nothing is ejected.
- Latency: exactly 1 cycle from input to every output. There is no backpressure: the local sink must accept lad every cycle.
- Combinational inputs may change every cycle. Each cycle is evaluated independently, except for the RR pointer.
- No eligible flit: lad=0 and all four slots pass through.
- All four eligible: only the priority winner is ejected; the other three pass through.
- Flit conservation: the number of valid bits summed over outputs equals the number of valid inputs from the previous cycle.

Optional Feature:
- Macro EJECT_RR_EN.
- Defined:
  - A 2-bit round-robin pointer (0=N, 1=S, 2=E, 3=W, reset 0) sets the starting point of the priority scan.
  - Scan order from the pointer: ptr, ptr+1, ... mod 4.
  - After a cycle with an ejection, the pointer moves to (winner+1) mod 4. Otherwise it holds.
  - The pointer is reset synchronously by rst.
- Not defined: fixed priority N>S>E>W and no pointer state.

Test Plan:
- Reset: rst=1 for 2 cycles with arbitrary inputs -> all outputs 11'b0. Then rst=0 with N=11'h000, S=11'b00000000101, E=11'b10000100100, W=11'b00000100100 -> next cycle lad=11'b10000100100, ead=0, nad=0, sad=11'b00000000101, wad=11'b00000100100.
- Fixed priority: N=11'b10000100100 and E=11'b10000100100 both eligible, S=11'b00000111111, W=11'b00000011100 -> lad=N value, nad=0, ead=11'b10000100100, sad and wad unchanged.
- Address mismatch: E=11'b10000101100 (addr 101100), others invalid -> lad=0, ead=11'b10000101100.
- Invalid with matching address: W=11'b00000100100 -> not ejected, lad=0, wad=11'b00000100100.
- Back-to-back: alternate eligible-on-W and none for 4 cycles -> lad toggles between W flit and 0 with 1-cycle latency.
- RR (EJECT_RR_EN): all four eligible for 4 consecutive cycles -> ejection order N, S, E, W. Without the macro -> N every cycle.

Source files
------------

// File: rtl/ejector_i.sv
// ejector_i: MinBD ejection stage; northad/southad/eastad/westad in, registered nad/sad/ead/wad to router and lad to local core, EJECT_RR_EN selects round-robin instead of fixed N>S>E>W priority
module ejector_i #(
  parameter int FLIT_W = 11,
  parameter logic [5:0] LOCAL_ADDR = 6'b100100
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [FLIT_W-1:0] northad,
  input  logic [FLIT_W-1:0] southad,
  input  logic [FLIT_W-1:0] eastad,
  input  logic [FLIT_W-1:0] westad,
  output logic [FLIT_W-1:0] nad,
  output logic [FLIT_W-1:0] sad,
  output logic [FLIT_W-1:0] ead,
  output logic [FLIT_W-1:0] wad,
  output logic [FLIT_W-1:0] lad
);
  logic [3:0][FLIT_W-1:0] fin;
  logic [3:0] elig;
  logic [1:0] ptr, win;
  logic hit;
  assign fin = {westad, eastad, southad, northad};
  for (genvar i = 0; i < 4; i++) begin : g_elig
    assign elig[i] = fin[i][FLIT_W-1] && fin[i][5:0] == LOCAL_ADDR;
  end
  always_comb begin
    win = ptr;
    hit = 1'b0;
    for (int k = 3; k >= 0; k--) begin
      if (elig[ptr + 2'(k)]) begin
        win = ptr + 2'(k);
        hit = 1'b1;
      end
    end
  end
`ifdef EJECT_RR_EN
  always_ff @(posedge clk)
    if (rst) ptr <= 2'd0;
    else if (hit) ptr <= win + 2'd1;
`else
  assign ptr = 2'd0;
`endif
  always_ff @(posedge clk) begin
    if (rst) begin
      nad <= '0;
      sad <= '0;
      ead <= '0;
      wad <= '0;
      lad <= '0;
    end else begin
      nad <= hit && win == 2'd0 ? '0 : northad;
      sad <= hit && win == 2'd1 ? '0 : southad;
      ead <= hit && win == 2'd2 ? '0 : eastad;
      wad <= hit && win == 2'd3 ? '0 : westad;
      lad <= hit ? fin[win] : '0;
    end
  end
endmodule

// File: tb/tb_ejector_i.sv
// tb_ejector_i: directed vector bench for ejector_i
module tb_ejector_i;
  logic clk = 1'b0, rst = 1'b1;
  logic [10:0] northad = '0, southad = '0, eastad = '0, westad = '0;
  logic [10:0] nad, sad, ead, wad, lad;
  int n_chk = 0, n_fail = 0;
  typedef struct {
    logic [10:0] n, s, e, w, xn, xs, xe, xw, xl;
  } vec_t;
  vec_t v[9];
  ejector_i dut (
    .clk(clk), .rst(rst),
    .northad(northad), .southad(southad), .eastad(eastad), .westad(westad),
    .nad(nad), .sad(sad), .ead(ead), .wad(wad), .lad(lad)
  );
  always #5 clk = ~clk;
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic check(input string name, input logic [10:0] act, input logic [10:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask
  task automatic drive(input logic [10:0] n, s, e, w);
    northad = n;
    southad = s;
    eastad  = e;
    westad  = w;
  endtask
  task automatic check_all(input string tag, input logic [10:0] xn, xs, xe, xw, xl);
    check({tag, ".nad"}, nad, xn);
    check({tag, ".sad"}, sad, xs);
    check({tag, ".ead"}, ead, xe);
    check({tag, ".wad"}, wad, xw);
    check({tag, ".lad"}, lad, xl);
  endtask
  initial begin
    v[0] = '{11'h000, 11'h005, 11'h424, 11'h024, 11'h000, 11'h005, 11'h000, 11'h024, 11'h424};
    v[1] = '{11'h424, 11'h03F, 11'h424, 11'h01C, 11'h000, 11'h03F, 11'h424, 11'h01C, 11'h424};
    v[2] = '{11'h000, 11'h000, 11'h42C, 11'h000, 11'h000, 11'h000, 11'h42C, 11'h000, 11'h000};
    v[3] = '{11'h000, 11'h000, 11'h000, 11'h024, 11'h000, 11'h000, 11'h000, 11'h024, 11'h000};
    v[4] = '{11'h000, 11'h000, 11'h000, 11'h424, 11'h000, 11'h000, 11'h000, 11'h000, 11'h424};
    v[5] = '{11'h000, 11'h000, 11'h000, 11'h000, 11'h000, 11'h000, 11'h000, 11'h000, 11'h000};
    v[6] = '{11'h000, 11'h000, 11'h000, 11'h5E4, 11'h000, 11'h000, 11'h000, 11'h000, 11'h5E4};
    v[7] = '{11'h000, 11'h000, 11'h000, 11'h000, 11'h000, 11'h000, 11'h000, 11'h000, 11'h000};
    v[8] = '{11'h7FF, 11'h400, 11'h465, 11'h3E4, 11'h7FF, 11'h400, 11'h465, 11'h3E4, 11'h000};
    rst = 1'b1;
    drive(11'h424, 11'h424, 11'h7FF, 11'h5A5);
    step();
    step();
    check_all("reset", '0, '0, '0, '0, '0);
    rst = 1'b0;
    for (int i = 0; i < 9; i++) begin
      drive(v[i].n, v[i].s, v[i].e, v[i].w);
      step();
      check_all($sformatf("vec%0d", i), v[i].xn, v[i].xs, v[i].xe, v[i].xw, v[i].xl);
    end
    drive(11'h424, 11'h424, 11'h424, 11'h424);
    rst = 1'b1;
    step();
    check_all("rst_prio", '0, '0, '0, '0, '0);
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      int w;
`ifdef EJECT_RR_EN
      w = k;
`else
      w = 0;
`endif
      step();
      check_all($sformatf("all4_%0d", k), w == 0 ? 11'h0 : 11'h424, w == 1 ? 11'h0 : 11'h424,
                w == 2 ? 11'h0 : 11'h424, w == 3 ? 11'h0 : 11'h424, 11'h424);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
